// File: rtl/mem_resp_router.sv
// Return-path router for the unified memory: an in-order tag FIFO records who issued
// each request (IF or MEM) and steers each returned word to that stage through registered outputs.
module mem_resp_router #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_fire,
    input  logic                     req_sel,
    input  logic                     resp_valid,
    input  logic [DATA_W-1:0]        resp_data,
    input  logic                     flush,
    output logic                     if_valid,
    output logic [DATA_W-1:0]        if_data,
    output logic                     dm_valid,
    output logic [DATA_W-1:0]        dm_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     err_overflow,
    output logic                     err_unexpected
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // There is no backpressure: a response is consumed in the cycle resp_valid is high,
    // and if_valid/dm_valid are single-cycle pulses that the stages must take unconditionally.
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [DEPTH-1:0] sel_q, killed_q;
    logic             pop, push_ok, overflow, unexpected;
    logic             head_sel, head_killed;

    always_comb begin
        pop         = resp_valid && (count != '0);
        push_ok     = req_fire && ((count < DEPTH_C) || pop);
        overflow    = req_fire && !push_ok;
        unexpected  = resp_valid && (count == '0);
        head_sel    = sel_q[rd_ptr];
        // A flush in the pop cycle also suppresses the word being popped
        head_killed = killed_q[rd_ptr] | flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            sel_q          <= '0;
            killed_q       <= '0;
            if_valid       <= 1'b0;
            dm_valid       <= 1'b0;
            if_data        <= '0;
            dm_data        <= '0;
            err_overflow   <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            // Killing every slot is safe: free slots get killed cleared when next written
            if (flush) killed_q <= '1;
            if (push_ok) begin
                sel_q[wr_ptr]    <= req_sel;
                killed_q[wr_ptr] <= 1'b0;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      count <= count + CW'(1);
            else if (pop && !push_ok) count <= count - CW'(1);

            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            if (pop && !head_killed) begin
                if (head_sel) begin
                    dm_valid <= 1'b1;
                    dm_data  <= resp_data;
                end else begin
                    if_valid <= 1'b1;
                    if_data  <= resp_data;
                end
            end
            if (overflow)   err_overflow   <= 1'b1;
            if (unexpected) err_unexpected <= 1'b1;
        end
    end

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
endmodule

// File: tb/tb_mem_resp_router.sv
// Bench for mem_resp_router: directed scenarios plus random traffic, all checked against
// a queue-based model of outstanding requests.
module tb_mem_resp_router;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst, req_fire, req_sel, resp_valid, flush;
    logic [DATA_W-1:0] resp_data;
    logic              if_valid, dm_valid, full, empty, err_overflow, err_unexpected;
    logic [DATA_W-1:0] if_data, dm_data;
    logic [CW-1:0]     count;

    mem_resp_router #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_fire(req_fire), .req_sel(req_sel),
        .resp_valid(resp_valid), .resp_data(resp_data), .flush(flush),
        .if_valid(if_valid), .if_data(if_data), .dm_valid(dm_valid), .dm_data(dm_data),
        .count(count), .full(full), .empty(empty),
        .err_overflow(err_overflow), .err_unexpected(err_unexpected)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic sel; logic killed; } tag_t;
    tag_t              tag_q[$];
    logic [DATA_W-1:0] exp_q[$];   // words expected on the next routed pulse
    logic              m_if_valid, m_dm_valid, m_err_ovf, m_err_unx;
    logic [DATA_W-1:0] m_if_data, m_dm_data;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model by the same edge, compare everything.
    task automatic cycle(input logic fire, input logic sel, input logic rv,
                         input logic [DATA_W-1:0] data, input logic fl, input logic r);
        int   n;
        tag_t e;
        req_fire = fire; req_sel = sel; resp_valid = rv; resp_data = data; flush = fl; rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            tag_q.delete();
            m_if_valid = 0; m_dm_valid = 0; m_if_data = '0; m_dm_data = '0;
            m_err_ovf = 0; m_err_unx = 0;
        end else begin
            n = tag_q.size();
            m_if_valid = 0; m_dm_valid = 0;
            if (fl) foreach (tag_q[i]) tag_q[i].killed = 1'b1;
            if (rv && n > 0) begin
                e = tag_q.pop_front();
                if (!e.killed) begin
                    if (e.sel) begin m_dm_valid = 1; m_dm_data = data; end
                    else       begin m_if_valid = 1; m_if_data = data; end
                end
            end
            if (rv && n == 0) m_err_unx = 1;
            if (fire) begin
                if (n < DEPTH || (rv && n > 0)) tag_q.push_back('{sel: sel, killed: 1'b0});
                else m_err_ovf = 1;
            end
        end
        check("if_valid", 64'(if_valid), 64'(m_if_valid));
        check("dm_valid", 64'(dm_valid), 64'(m_dm_valid));
        check("if_data", 64'(if_data), 64'(m_if_data));
        check("dm_data", 64'(dm_data), 64'(m_dm_data));
        check("count", 64'(count), 64'(tag_q.size()));
        check("full", 64'(full), 64'(tag_q.size() == DEPTH));
        check("empty", 64'(empty), 64'(tag_q.size() == 0));
        check("err_overflow", 64'(err_overflow), 64'(m_err_ovf));
        check("err_unexpected", 64'(err_unexpected), 64'(m_err_unx));
        if (m_if_valid || m_dm_valid) begin
            if (exp_q.size() > 0) begin
                check("routed_word", 64'(m_if_valid ? if_data : dm_data), 64'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, '0, 0, 0);
    endtask

    task automatic push(input logic sel);
        cycle(1, sel, 0, '0, 0, 0);
    endtask

    task automatic resp(input logic [DATA_W-1:0] d);
        cycle(0, 0, 1, d, 0, 0);
    endtask

    initial begin
        req_fire = 0; req_sel = 0; resp_valid = 0; resp_data = '0; flush = 0; rst = 1;
        m_if_valid = 0; m_dm_valid = 0; m_if_data = '0; m_dm_data = '0;
        m_err_ovf = 0; m_err_unx = 0;

        // Reset then idle
        cycle(0, 0, 0, '0, 0, 1);
        cycle(1, 1, 1, 32'hDEAD_BEEF, 1, 1);
        for (int i = 0; i < 10; i++) idle();
        check("reset_count", 64'(count), 64'd0);
        check("reset_empty", 64'(empty), 64'd1);

        // Interleaved routing
        push(0); push(1); push(0);
        exp_q.push_back(32'hAAAA0001); exp_q.push_back(32'hBBBB0002); exp_q.push_back(32'hCCCC0003);
        resp(32'hAAAA0001);
        check("ilv_if1", 64'({if_valid, if_data}), 64'({1'b1, 32'hAAAA0001}));
        resp(32'hBBBB0002);
        check("ilv_dm2", 64'({dm_valid, dm_data}), 64'({1'b1, 32'hBBBB0002}));
        resp(32'hCCCC0003);
        check("ilv_if3", 64'({if_valid, if_data}), 64'({1'b1, 32'hCCCC0003}));
        idle();
        check("ilv_empty", 64'(empty), 64'd1);

        // Full and wrap
        for (int i = 0; i < DEPTH; i++) push(1'(i));
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1'(i + 1), 1, 32'h5000_0000 + 32'(i), 0, 0);
            check("wrap_full", 64'(full), 64'd1);
            check("wrap_count", 64'(count), 64'(DEPTH));
        end
        check("wrap_no_ovf", 64'(err_overflow), 64'd0);
        push(1);
        check("ovf_flag", 64'(err_overflow), 64'd1);
        check("ovf_count", 64'(count), 64'(DEPTH));

        // Flush
        cycle(0, 0, 0, '0, 0, 1);
        push(0); push(0); push(1);
        cycle(1, 1, 0, '0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            resp(32'h7000_0000 + 32'(i));
            check("flush_quiet", 64'({if_valid, dm_valid}), 64'd0);
        end
        resp(32'h7000_0003);
        check("flush_dm4", 64'({dm_valid, dm_data}), 64'({1'b1, 32'h7000_0003}));

        // Unexpected response
        resp(32'h12345678);
        check("unx_quiet", 64'({if_valid, dm_valid}), 64'd0);
        check("unx_flag", 64'(err_unexpected), 64'd1);
        for (int i = 0; i < 3; i++) idle();
        check("unx_sticky", 64'(err_unexpected), 64'd1);

        // Mid-operation reset
        push(0); push(1); push(0);
        cycle(0, 0, 0, '0, 0, 1);
        check("mid_rst_unx_clr", 64'(err_unexpected), 64'd0);
        resp(32'h0BAD_0BAD);
        check("mid_rst_quiet", 64'({if_valid, dm_valid}), 64'd0);
        check("mid_rst_unx", 64'(err_unexpected), 64'd1);
        check("mid_rst_count", 64'(count), 64'd0);

        // Random traffic, occasionally flushed or reset
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 99) < 50), $urandom(),
                  1'($urandom_range(0, 99) < 4), 1'($urandom_range(0, 999) < 5));
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule
